spi_slave: RTL

Single-chip-select SPI slave endpoint clocked from the system clock. It oversamples `sclk`, `mosi` and `ss_n` from an SPI_master, shifts received bits into a word and returns a preloaded word on `miso` in the same frame. It is the downstream peer of SPI_master, and the default loopback partner for master benches.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_sync_edge.sv | 37 +++
 rtl/spi_slave.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encoding, mode decode helpers, synchronizer depth.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
// Contents: spi_mode_t (bit1 = CPOL, bit0 = CPHA), cpol(), cpha(), SYNC_STAGES.
package spi_pkg;

  typedef logic [1:0] spi_mode_t;

  // Flops in each pin synchronizer, not counting the edge-detect history flop.
  localparam int SYNC_STAGES = 2;

  function automatic logic cpol(input spi_mode_t mode);
    return mode[1];
  endfunction

  function automatic logic cpha(input spi_mode_t mode);
    return mode[0];
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Pin synchronizer with a history flop for single-cycle rise/fall detection.
// Latency: SYNC_STAGES clk to sync; rise/fall are combinational on sync/history.
// Backpressure: none; the input is sampled every clk cycle.
// Ports: clk, rst_n (async, active low), din (asynchronous pin),
//        sync (synchronized level), rise/fall (one-cycle edge strobes).
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] stages;
  logic                   hist;

  // Reset to the pin's idle level so releasing reset never produces an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stages <= {SYNC_STAGES{RST_VAL}};
      hist   <= RST_VAL;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], din};
      hist   <= stages[SYNC_STAGES-1];
    end
  end

  assign sync = stages[SYNC_STAGES-1];
  assign rise = sync & ~hist;
  assign fall = ~sync & hist;

endmodule

// File: rtl/spi_slave.sv
// SPI slave endpoint: oversamples sclk/mosi/ss_n, receives a word, returns the buffered TX word.
// Latency: 3 clk from pin edge to action; rx_valid 3-4 clk after the final sample edge.
// Backpressure: none on RX (rx_data overwritten per word); TX empty at word start -> zeros + tx_underrun.
// Ports: clk, rst_n (async, active low); SPI pins sclk, mosi, ss_n, miso;
//        tx_data/tx_load/tx_ready (TX buffer), rx_data/rx_valid (received word),
//        busy (slave selected), tx_underrun (word started with an empty buffer).
module spi_slave
  import spi_pkg::*;
#(
  parameter int SPI_MODE   = 0,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  ss_n,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  tx_underrun
);

  localparam spi_mode_t       MODE      = spi_mode_t'(SPI_MODE);
  localparam logic            MODE_CPOL = cpol(MODE);
  localparam logic            MODE_CPHA = cpha(MODE);
  localparam int              CNT_W     = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  // Synchronized pins
  logic sclk_sync_unused, sclk_rise, sclk_fall;
  logic ss_sync, ss_rise, ss_fall;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.RST_VAL(MODE_CPOL)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(sclk),
    .sync(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst_n(rst_n), .din(ss_n),
    .sync(ss_sync), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(mosi),
    .sync(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  // Datapath state
  logic                  active;
  logic [1:0]            arm_cnt;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-2:0] rx_shift;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] tx_buf;
  logic                  tx_full;
  logic                  miso_q;

  logic                  armed;
  logic                  lead_edge, trail_edge;
  logic                  sample_edge, shift_edge;
  logic                  word_done, frame_start, word_start;
  logic [DATA_WIDTH-1:0] tx_word;
  logic [DATA_WIDTH-1:0] rx_next;

  // The ss_n synchronizer resets to "deselected"; if the pin is already low
  // when reset releases, that would look like a fall. Only accept a fall once
  // ss_n has been seen high for a few real samples.
  assign armed = (arm_cnt == 2'd3);

  assign lead_edge   = MODE_CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = MODE_CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = active & (MODE_CPHA ? trail_edge : lead_edge);
  assign shift_edge  = active & (MODE_CPHA ? lead_edge : trail_edge);

  assign word_done   = sample_edge & (bit_cnt == LAST_BIT);
  assign frame_start = ss_fall & armed & ~active;
  // A word completing on the same cycle ss_n rises ends the frame instead.
  assign word_start  = frame_start | (word_done & ~ss_rise);

  assign tx_word = tx_full ? tx_buf : '0;
  assign rx_next = {rx_shift, mosi_sync};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active      <= 1'b0;
      arm_cnt     <= 2'd0;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      tx_buf      <= '0;
      tx_full     <= 1'b0;
      miso_q      <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;

      if (!ss_sync) begin
        arm_cnt <= 2'd0;
      end else if (arm_cnt != 2'd3) begin
        arm_cnt <= arm_cnt + 2'd1;
      end

      // A load always wins, so a load coinciding with word start is kept
      // for the following word.
      if (tx_load) begin
        tx_buf  <= tx_data;
        tx_full <= 1'b1;
      end else if (word_start) begin
        tx_full <= 1'b0;
      end

      if (frame_start) begin
        active <= 1'b1;
      end

      if (sample_edge) begin
        rx_shift <= rx_next[DATA_WIDTH-2:0];
        if (word_done) begin
          rx_data  <= rx_next;
          rx_valid <= 1'b1;
          bit_cnt  <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      // CPHA=0: the trailing edge that follows the final sample belongs to
      // the finished word; the next MSB is already on miso, so hold it.
      if (shift_edge && (MODE_CPHA || (bit_cnt != '0))) begin
        miso_q   <= tx_shift[DATA_WIDTH-1];
        tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
      end

      if (word_start) begin
        tx_underrun <= ~tx_full;
        if (MODE_CPHA) begin
          // MSB is presented by the first leading edge.
          tx_shift <= tx_word;
        end else begin
          miso_q   <= tx_word[DATA_WIDTH-1];
          tx_shift <= {tx_word[DATA_WIDTH-2:0], 1'b0};
        end
      end

      // Deselect: drop any partial word; the TX buffer is left untouched.
      if (ss_rise) begin
        active   <= 1'b0;
        bit_cnt  <= '0;
        rx_shift <= '0;
        miso_q   <= 1'b0;
      end
    end
  end

  assign miso     = miso_q;
  assign tx_ready = ~tx_full;
  assign busy     = ~ss_sync;

endmodule
